// File: rtl/pipeline_controller_pkg.sv
// Shared encodings and control-bundle types for the pipelined ARM controller.
// Holds the op, ALU, condition-code and forward-select constants.
package pipeline_controller_pkg;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_control;
      logic [1:0] flag_w;
      logic       pc_src;
   } ctrl_t;

   // flags are packed {N, Z, C, V}
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      {n, z, c, v} = flags;
      case (cond)
         COND_EQ: cond_eval = z;
         COND_NE: cond_eval = ~z;
         COND_CS: cond_eval = c;
         COND_CC: cond_eval = ~c;
         COND_MI: cond_eval = n;
         COND_PL: cond_eval = ~n;
         COND_VS: cond_eval = v;
         COND_VC: cond_eval = ~v;
         COND_HI: cond_eval = c & ~z;
         COND_LS: cond_eval = ~(c & ~z);
         COND_GE: cond_eval = (n == v);
         COND_LT: cond_eval = (n != v);
         COND_GT: cond_eval = ~z & (n == v);
         COND_LE: cond_eval = ~(~z & (n == v));
         COND_AL: cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_controller_cond_unit.sv
// NZCV flags register and Execute-stage condition evaluation.
// Each flag half only updates when its write enable is set and the instruction passes.
module cond_unit
   import pipeline_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   output logic       cond_ex
);

   logic [3:0] flags;

   assign cond_ex = cond_eval(cond, flags);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags <= 4'b0000;
      end else begin
         if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
         if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
      end
   end

endmodule

// File: rtl/pipeline_controller.sv
// Control and hazard unit for the five-stage pipelined ARM datapath: decode,
// E/M/W control registers, forwarding selects and stall/flush generation.
module pipeline_controller
   import pipeline_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] InstrD,
   input  logic [3:0]  ALUFlagsE,
   input  logic        Match_1E_M,
   input  logic        Match_1E_W,
   input  logic        Match_2E_M,
   input  logic        Match_2E_W,
   input  logic        Match_12D_E,
   output logic [1:0]  RegSrcD,
   output logic [1:0]  ImmSrcD,
   output logic        ALUSrcE,
   output logic [1:0]  ALUControlE,
   output logic        BranchTakenE,
   output logic        MemWriteM,
   output logic        MemtoRegW,
   output logic        PCSrcW,
   output logic        RegWriteW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD
);

   logic [3:0] cond_d;
   logic [1:0] op_d;
   logic [5:0] funct_d;
   logic [3:0] rd_d;
   logic       unused_instr;

   ctrl_t      ctrl_d;
   ctrl_t      ctrl_e;
   logic [3:0] cond_e;
   logic       cond_ex_e;

   logic       reg_write_m;
   logic       mem_to_reg_m;
   logic       pc_src_m;

   logic       ldr_stall;
   logic       pc_wr_pending;
   logic       flush_e;

   assign cond_d       = InstrD[31:28];
   assign op_d         = InstrD[27:26];
   assign funct_d      = InstrD[25:20];
   assign rd_d         = InstrD[15:12];
   assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

   assign ImmSrcD = op_d;

   always_comb begin
      ctrl_d  = '0;
      RegSrcD = 2'b00;
      case (op_d)
         OP_DP: begin
            ctrl_d.alu_src   = funct_d[5];
            ctrl_d.reg_write = 1'b1;
            case (funct_d[4:1])
               CMD_ADD: ctrl_d.alu_control = ALU_ADD;
               CMD_SUB: ctrl_d.alu_control = ALU_SUB;
               CMD_AND: ctrl_d.alu_control = ALU_AND;
               CMD_ORR: ctrl_d.alu_control = ALU_ORR;
               default: begin
                  ctrl_d.alu_control = ALU_ADD;
                  ctrl_d.reg_write   = 1'b0;
               end
            endcase
            // only arithmetic ops touch C and V
            ctrl_d.flag_w[1] = funct_d[0];
            ctrl_d.flag_w[0] = funct_d[0] &
                               ((funct_d[4:1] == CMD_ADD) | (funct_d[4:1] == CMD_SUB));
         end
         OP_MEM: begin
            ctrl_d.alu_src     = 1'b1;
            ctrl_d.alu_control = ALU_ADD;
            if (funct_d[0]) begin
               ctrl_d.reg_write  = 1'b1;
               ctrl_d.mem_to_reg = 1'b1;
            end else begin
               ctrl_d.mem_write = 1'b1;
               RegSrcD[1]       = 1'b1;
            end
         end
         OP_BR: begin
            ctrl_d.branch      = 1'b1;
            ctrl_d.alu_src     = 1'b1;
            ctrl_d.alu_control = ALU_ADD;
            RegSrcD[0]         = 1'b1;
         end
         default: ;
      endcase
      ctrl_d.pc_src = (rd_d == 4'hF) & ctrl_d.reg_write;
   end

   // D->E: a flush leaves a bubble by dropping every side-effecting bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_e <= '0;
         cond_e <= 4'b0000;
      end else begin
         ctrl_e <= ctrl_d;
         cond_e <= cond_d;
         if (flush_e) begin
            ctrl_e.reg_write <= 1'b0;
            ctrl_e.mem_write <= 1'b0;
            ctrl_e.branch    <= 1'b0;
            ctrl_e.flag_w    <= 2'b00;
            ctrl_e.pc_src    <= 1'b0;
         end
      end
   end

   cond_unit u_cond_unit (
      .clk       (clk),
      .reset     (reset),
      .cond      (cond_e),
      .alu_flags (ALUFlagsE),
      .flag_w    (ctrl_e.flag_w),
      .cond_ex   (cond_ex_e)
   );

   assign ALUSrcE      = ctrl_e.alu_src;
   assign ALUControlE  = ctrl_e.alu_control;
   assign BranchTakenE = ctrl_e.branch & cond_ex_e;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_write_m  <= 1'b0;
         MemWriteM    <= 1'b0;
         mem_to_reg_m <= 1'b0;
         pc_src_m     <= 1'b0;
         RegWriteW    <= 1'b0;
         MemtoRegW    <= 1'b0;
         PCSrcW       <= 1'b0;
      end else begin
         reg_write_m  <= ctrl_e.reg_write & cond_ex_e;
         MemWriteM    <= ctrl_e.mem_write & cond_ex_e;
         mem_to_reg_m <= ctrl_e.mem_to_reg;
         pc_src_m     <= ctrl_e.pc_src & cond_ex_e;
         RegWriteW    <= reg_write_m;
         MemtoRegW    <= mem_to_reg_m;
         PCSrcW       <= pc_src_m;
      end
   end

   always_comb begin
      if (Match_1E_M && reg_write_m)    ForwardAE = FWD_MEM;
      else if (Match_1E_W && RegWriteW) ForwardAE = FWD_WB;
      else                              ForwardAE = FWD_RF;
      if (Match_2E_M && reg_write_m)    ForwardBE = FWD_MEM;
      else if (Match_2E_W && RegWriteW) ForwardBE = FWD_WB;
      else                              ForwardBE = FWD_RF;
   end

   // load-use detection looks at the unqualified Execute write enable
   assign ldr_stall     = Match_12D_E & ctrl_e.mem_to_reg & ctrl_e.reg_write;
   assign pc_wr_pending = ctrl_d.pc_src | ctrl_e.pc_src | pc_src_m;
   assign StallD        = ldr_stall;
   assign StallF        = ldr_stall | pc_wr_pending;
   assign FlushD        = pc_wr_pending | PCSrcW | BranchTakenE;
   assign flush_e       = ldr_stall | BranchTakenE;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed, table-driven bench for pipeline_controller with hand-computed expectations,
// plus hand sequences for asynchronous reset in mid-stream.
module tb_pipeline_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] InstrD;
   logic [3:0]  ALUFlagsE;
   logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
   logic [1:0]  RegSrcD, ImmSrcD, ALUControlE, ForwardAE, ForwardBE;
   logic        ALUSrcE, BranchTakenE, MemWriteM, MemtoRegW, PCSrcW, RegWriteW;
   logic        StallF, StallD, FlushD;

   always #5 clk = ~clk;

   pipeline_controller dut (
      .clk          (clk),
      .reset        (reset),
      .InstrD       (InstrD),
      .ALUFlagsE    (ALUFlagsE),
      .Match_1E_M   (Match_1E_M),
      .Match_1E_W   (Match_1E_W),
      .Match_2E_M   (Match_2E_M),
      .Match_2E_W   (Match_2E_W),
      .Match_12D_E  (Match_12D_E),
      .RegSrcD      (RegSrcD),
      .ImmSrcD      (ImmSrcD),
      .ALUSrcE      (ALUSrcE),
      .ALUControlE  (ALUControlE),
      .BranchTakenE (BranchTakenE),
      .MemWriteM    (MemWriteM),
      .MemtoRegW    (MemtoRegW),
      .PCSrcW       (PCSrcW),
      .RegWriteW    (RegWriteW),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD)
   );

   localparam logic [31:0] I_LDR     = 32'hE590_1000;  // LDR  R1,[R0]
   localparam logic [31:0] I_ADD_R2  = 32'hE081_2001;  // ADD  R2,R1,R1
   localparam logic [31:0] I_SUBS    = 32'hE054_3005;  // SUBS R3,R4,R5
   localparam logic [31:0] I_ADD_R6I = 32'hE283_6001;  // ADD  R6,R3,#1
   localparam logic [31:0] I_ADDEQ   = 32'h0080_7000;  // ADDEQ R7,R0,R0
   localparam logic [31:0] I_NOP     = 32'hEC00_0000;  // op=11, no control
   localparam logic [31:0] I_B       = 32'hEA00_0000;  // B (AL)
   localparam logic [31:0] I_ADDPC   = 32'hE280_F008;  // ADD  PC,R0,#8
   localparam logic [31:0] I_STRNE   = 32'h1580_1000;  // STRNE R1,[R0]
   localparam logic [31:0] I_SUBSNE  = 32'h1054_3005;  // SUBSNE R3,R4,R5
   localparam logic [31:0] I_STR     = 32'hE580_1000;  // STR  R1,[R0]

   // field order: RegSrcD ImmSrcD ALUSrcE ALUControlE BranchTakenE MemWriteM
   //              MemtoRegW PCSrcW RegWriteW ForwardAE ForwardBE StallF StallD FlushD
   typedef logic [18:0] outs_t;

   // match order: {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E}
   typedef struct {
      logic [31:0] instr;
      logic [3:0]  flags;
      logic [4:0]  match;
      outs_t       exp;
   } vec_t;

   localparam int NV = 29;
   vec_t  v [NV];
   outs_t act;
   int    checks = 0;
   int    errors = 0;

   assign act = {RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
                 MemtoRegW, PCSrcW, RegWriteW, ForwardAE, ForwardBE, StallF, StallD, FlushD};

   task automatic check(input string name, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b want=%b", name, act, exp);
      end
   endtask

   initial begin
      // load-use: LDR then dependent ADD
      v[0]  = '{I_LDR,     4'h0, 5'b00000, 19'b00_01_0_00_0_0_0_0_0_00_00_0_0_0};
      v[1]  = '{I_ADD_R2,  4'h0, 5'b00001, 19'b00_00_1_00_0_0_0_0_0_00_00_1_1_0};
      v[2]  = '{I_ADD_R2,  4'h0, 5'b00000, 19'b00_00_0_00_0_0_0_0_0_00_00_0_0_0};
      v[3]  = '{I_NOP,     4'h0, 5'b01010, 19'b00_11_0_00_0_0_1_0_1_01_01_0_0_0};
      // back-to-back ALU, Memory beats Writeback, Z set then ADDEQ executes
      v[4]  = '{I_SUBS,    4'h0, 5'b11010, 19'b00_00_0_00_0_0_0_0_0_10_00_0_0_0};
      v[5]  = '{I_ADD_R6I, 4'h4, 5'b00000, 19'b00_00_0_01_0_0_0_0_1_00_00_0_0_0};
      v[6]  = '{I_ADDEQ,   4'h0, 5'b10000, 19'b00_00_1_00_0_0_0_0_0_10_00_0_0_0};
      v[7]  = '{I_NOP,     4'hF, 5'b00000, 19'b00_11_0_00_0_0_0_0_1_00_00_0_0_0};
      v[8]  = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_1_00_00_0_0_0};
      v[9]  = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_1_00_00_0_0_0};
      // taken branch, wrong-path ADD becomes a bubble that never writes back
      v[10] = '{I_B,       4'h0, 5'b00000, 19'b01_10_0_00_0_0_0_0_0_00_00_0_0_0};
      v[11] = '{I_ADD_R2,  4'h0, 5'b00000, 19'b00_00_1_00_1_0_0_0_0_00_00_0_0_1};
      v[12] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0};
      v[13] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0};
      v[14] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0};
      // write to R15
      v[15] = '{I_ADDPC,   4'h0, 5'b00000, 19'b00_00_0_00_0_0_0_0_0_00_00_1_0_1};
      v[16] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_1_00_0_0_0_0_0_00_00_1_0_1};
      v[17] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_0_00_00_1_0_1};
      v[18] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_1_1_00_00_0_0_1};
      // condition fail with Z=1: STRNE and SUBSNE suppressed, flags keep Z
      v[19] = '{I_STRNE,   4'h0, 5'b00000, 19'b10_01_0_00_0_0_0_0_0_00_00_0_0_0};
      v[20] = '{I_SUBSNE,  4'h0, 5'b00000, 19'b00_00_1_00_0_0_0_0_0_00_00_0_0_0};
      v[21] = '{I_ADDEQ,   4'h0, 5'b00000, 19'b00_00_0_01_0_0_0_0_0_00_00_0_0_0};
      v[22] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0};
      v[23] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0};
      v[24] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_1_00_00_0_0_0};
      // unconditional store reaches Memory
      v[25] = '{I_STR,     4'h0, 5'b00000, 19'b10_01_0_00_0_0_0_0_0_00_00_0_0_0};
      v[26] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_1_00_0_0_0_0_0_00_00_0_0_0};
      v[27] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_1_0_0_0_00_00_0_0_0};
      v[28] = '{I_NOP,     4'h0, 5'b00000, 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0};

      reset     = 1'b1;
      InstrD    = 32'h0;
      ALUFlagsE = 4'h0;
      {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = 5'b00000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 19'b0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         InstrD    = v[i].instr;
         ALUFlagsE = v[i].flags;
         {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = v[i].match;
         #3;
         check($sformatf("vec%0d", i), v[i].exp);
         @(posedge clk);
         #1;
      end

      // put a PC write and a store in flight, then reset between edges
      InstrD = I_ADDPC;
      @(posedge clk); #1;
      InstrD = I_STR;
      @(posedge clk); #1;
      InstrD = I_NOP;
      #3;
      check("inflight", 19'b00_11_1_00_0_0_0_0_0_00_00_1_0_1);
      #1;
      reset  = 1'b1;
      InstrD = 32'h0;
      #1;
      check("async_reset", 19'b0);

      @(posedge clk); #1;
      reset  = 1'b0;
      InstrD = I_ADDEQ;
      #3;
      check("post_reset", 19'b0);
      @(posedge clk); #1;
      InstrD = I_NOP;
      #3;
      check("first_edge", 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0);
      // Flags cleared to Z=0, so the ADDEQ must not reach RegWriteW
      @(posedge clk); #1;
      @(posedge clk); #1;
      #3;
      check("flags_cleared", 19'b00_11_0_00_0_0_0_0_0_00_00_0_0_0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
